fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle MIPS datapath. It holds the program counter, requests words from instruction memory over a req/ack handshake, and presents the fetched 32-bit instruction to decode. Decode uses `instruction[31:26]` as the `control` opcode input. On each retire handshake it consumes the `branch`, `jump` and ALU `zero` results and computes the next PC.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_unit_next_pc_logic.sv | 24 ++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch stage.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_STEP       = 4;
    localparam int unsigned OPCODE_MSB    = 31;
    localparam int unsigned OPCODE_LSB    = 26;
    localparam int unsigned JUMP_TARGET_W = 26;

    // Extracts the primary opcode field that decode feeds to control.
    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc_logic.sv
// Combinational next-PC selection: jump beats taken branch beats fall-through.
module next_pc_logic
    import cpu_pkg::*;
(
    input  logic [31:0]              pc_plus4,
    input  logic [JUMP_TARGET_W-1:0] jump_field,
    input  logic                     branch,
    input  logic                     zero,
    input  logic                     jump,
    input  logic [31:0]              branch_imm,
    output logic [31:0]              next_pc
);

    // Pick the retire target; the branch offset is in words, so scale by 4.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], jump_field, 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + (branch_imm << 2);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack handshake, instruction register
// and retire counter.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemRdata,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] branchImm,
    output logic [31:0] retireCount
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  count_q, count_d;
    logic         req_q, req_d;
    logic         valid_q, valid_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;

    assign pc_plus4 = pc_q + PC_STEP;

    next_pc_logic u_next_pc (
        .pc_plus4   (pc_plus4),
        .jump_field (instr_q[JUMP_TARGET_W-1:0]),
        .branch     (branch),
        .zero       (zero),
        .jump       (jump),
        .branch_imm (branchImm),
        .next_pc    (next_pc)
    );

    // Next-state logic; req/valid are computed alongside the state so they leave as flops.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        req_d   = req_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
            end
            FETCH: begin
                if (imemAck) begin
                    instr_d = imemRdata;
                    state_d = HOLD;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (instrReady) begin
                    pc_d    = next_pc;
                    count_d = count_q + 32'd1;
                    state_d = FETCH;
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any in-flight fetch or held instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            count_q <= 32'h0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    assign imemReq     = req_q;
    assign instrValid  = valid_q;
    assign imemAddr    = pc_q;
    assign pc          = pc_q;
    assign pcPlus4     = pc_plus4;
    assign instruction = instr_q;
    assign retireCount = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// reset/wrap sequences, then randomized traffic against a transaction model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk;
    logic        rst_n;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [31:0] branchImm;
    logic [31:0] retireCount;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ack;
        logic        ready;
        logic [31:0] rdata;
        logic        br;
        logic        z;
        logic        j;
        logic [31:0] imm;
        logic        expReq;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expInstr;
        logic [31:0] expCount;
    } vec_t;

    vec_t vecs[$];

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemAck     (imemAck),
        .imemRdata   (imemRdata),
        .instrValid  (instrValid),
        .instrReady  (instrReady),
        .instruction (instruction),
        .pc          (pc),
        .pcPlus4     (pcPlus4),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .branchImm   (branchImm),
        .retireCount (retireCount)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic er, input logic ev,
                            input logic [31:0] epc, input logic [31:0] ei, input logic [31:0] ec);
        checkOutput({tag, " imemReq"},     {31'b0, imemReq},    {31'b0, er});
        checkOutput({tag, " instrValid"},  {31'b0, instrValid}, {31'b0, ev});
        checkOutput({tag, " imemAddr"},    imemAddr,            epc);
        checkOutput({tag, " pc"},          pc,                  epc);
        checkOutput({tag, " pcPlus4"},     pcPlus4,             epc + 32'd4);
        checkOutput({tag, " instruction"}, instruction,         ei);
        checkOutput({tag, " retireCount"}, retireCount,         ec);
    endtask

    // Drive one cycle of inputs, let the edge happen, return 1 ns after it.
    task automatic applyStimulus(input logic ack, input logic ready, input logic [31:0] rdata,
                                 input logic br, input logic z, input logic j, input logic [31:0] imm);
        imemAck    = ack;
        instrReady = ready;
        imemRdata  = rdata;
        branch     = br;
        zero       = z;
        jump       = j;
        branchImm  = imm;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic ack, input logic ready, input logic [31:0] rdata,
                          input logic br, input logic z, input logic j, input logic [31:0] imm,
                          input logic er, input logic ev, input logic [31:0] epc,
                          input logic [31:0] ei, input logic [31:0] ec);
        vec_t v;
        v.ack = ack; v.ready = ready; v.rdata = rdata;
        v.br = br; v.z = z; v.j = j; v.imm = imm;
        v.expReq = er; v.expValid = ev; v.expPc = epc; v.expInstr = ei; v.expCount = ec;
        vecs.push_back(v);
    endtask

    // Transaction-level model state: what the fetch stage should be showing.
    logic        mReq, mValid;
    logic [31:0] mPc, mInstr, mCount;

    function automatic logic [31:0] modelTarget(input logic [31:0] curPc, input logic [31:0] instr,
                                                input logic br, input logic z, input logic j,
                                                input logic [31:0] imm);
        logic [31:0] seq;
        seq = curPc + 32'd4;
        if (j)            return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 32'd4);
        else if (br && z) return seq + imm * 32'd4;
        else              return seq;
    endfunction

    initial begin
        logic        rAck, rReady, rBr, rZ, rJ;
        logic [31:0] rData, rImm;

        rst_n = 1'b0;
        imemAck = 1'b0; instrReady = 1'b0; imemRdata = 32'h0;
        branch = 1'b0; zero = 1'b0; jump = 1'b0; branchImm = 32'h0;

        // Straight-line program: zero-wait run, wait states, branch/jump retires.
        addVec(1,1,32'h2001_0001, 0,0,0,32'h0,          0,1,32'h40, 32'h2001_0001, 0);
        addVec(1,1,32'hDEAD_BEEF, 0,0,0,32'h0,          1,0,32'h44, 32'h2001_0001, 1);
        addVec(1,1,32'h2002_0002, 0,0,0,32'h0,          0,1,32'h44, 32'h2002_0002, 1);
        addVec(0,1,32'h0,         0,0,0,32'h0,          1,0,32'h48, 32'h2002_0002, 2);
        addVec(1,1,32'h2003_0003, 0,0,0,32'h0,          0,1,32'h48, 32'h2003_0003, 2);
        addVec(0,1,32'h0,         0,0,0,32'h0,          1,0,32'h4C, 32'h2003_0003, 3);
        addVec(1,1,32'h2004_0004, 0,0,0,32'h0,          0,1,32'h4C, 32'h2004_0004, 3);
        addVec(0,1,32'h0,         0,0,0,32'h0,          1,0,32'h50, 32'h2004_0004, 4);
        addVec(0,1,32'h1111_1111, 0,0,0,32'h0,          1,0,32'h50, 32'h2004_0004, 4);
        addVec(0,1,32'h2222_2222, 0,0,0,32'h0,          1,0,32'h50, 32'h2004_0004, 4);
        addVec(0,1,32'h3333_3333, 0,0,0,32'h0,          1,0,32'h50, 32'h2004_0004, 4);
        addVec(1,0,32'h0800_0004, 0,0,0,32'h0,          0,1,32'h50, 32'h0800_0004, 4);
        addVec(1,0,32'hDEAD_BEEF, 0,0,0,32'h0,          0,1,32'h50, 32'h0800_0004, 4);
        addVec(1,0,32'hDEAD_BEEF, 0,0,0,32'h0,          0,1,32'h50, 32'h0800_0004, 4);
        addVec(1,0,32'hDEAD_BEEF, 0,0,0,32'h0,          0,1,32'h50, 32'h0800_0004, 4);
        addVec(0,1,32'h0,         0,0,1,32'h0,          1,0,32'h10, 32'h0800_0004, 5);
        addVec(1,0,32'h1000_FFFE, 0,0,0,32'h0,          0,1,32'h10, 32'h1000_FFFE, 5);
        addVec(0,1,32'h0,         1,1,0,32'hFFFF_FFFE,  1,0,32'h0C, 32'h1000_FFFE, 6);
        addVec(1,0,32'h2005_0005, 0,0,0,32'h0,          0,1,32'h0C, 32'h2005_0005, 6);
        addVec(0,1,32'h0,         0,0,0,32'h0,          1,0,32'h10, 32'h2005_0005, 7);
        addVec(1,0,32'h1000_FFFE, 0,0,0,32'h0,          0,1,32'h10, 32'h1000_FFFE, 7);
        addVec(0,1,32'h0,         1,0,0,32'hFFFF_FFFE,  1,0,32'h14, 32'h1000_FFFE, 8);
        addVec(1,0,32'h0800_0008, 0,0,0,32'h0,          0,1,32'h14, 32'h0800_0008, 8);
        addVec(0,1,32'h0,         0,0,1,32'h0,          1,0,32'h20, 32'h0800_0008, 9);
        addVec(1,0,32'h0800_0040, 0,0,0,32'h0,          0,1,32'h20, 32'h0800_0040, 9);
        addVec(0,1,32'h0,         1,1,1,32'hFFFF_FFFE,  1,0,32'h100,32'h0800_0040, 10);
        addVec(1,0,32'h0800_000C, 0,0,0,32'h0,          0,1,32'h100,32'h0800_000C, 10);
        addVec(0,1,32'h0,         0,0,1,32'h0,          1,0,32'h30, 32'h0800_000C, 11);
        addVec(1,0,32'h2006_0006, 0,0,0,32'h0,          0,1,32'h30, 32'h2006_0006, 11);

        // Reset state, then first request one cycle after release.
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 0, 0, RST_PC, 32'h0, 32'h0);
        rst_n = 1'b1;
        applyStimulus(0,0,32'h0,0,0,0,32'h0);
        checkAll("release", 1, 0, RST_PC, 32'h0, 32'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ack, vecs[i].ready, vecs[i].rdata,
                          vecs[i].br, vecs[i].z, vecs[i].j, vecs[i].imm);
            checkAll($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expValid,
                     vecs[i].expPc, vecs[i].expInstr, vecs[i].expCount);
        end

        // Asynchronous reset in HOLD at 0x30, with ready asserted so a retire would be visible.
        instrReady = 1'b1;
        rst_n = 1'b0;
        #1;
        checkAll("async reset", 0, 0, RST_PC, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        checkAll("in reset", 0, 0, RST_PC, 32'h0, 32'h0);
        rst_n = 1'b1;
        applyStimulus(0,0,32'h0,0,0,0,32'h0);
        checkAll("restart", 1, 0, RST_PC, 32'h0, 32'h0);

        // Branch backwards past zero to 0xFFFF_FFFC, then wrap forward to 0.
        applyStimulus(1,0,32'h1000_FFEE,0,0,0,32'h0);
        checkAll("wrap hold", 0, 1, RST_PC, 32'h1000_FFEE, 32'h0);
        applyStimulus(0,1,32'h0,1,1,0,32'hFFFF_FFEE);
        checkAll("wrap top", 1, 0, 32'hFFFF_FFFC, 32'h1000_FFEE, 32'h1);
        applyStimulus(1,0,32'h2007_0007,0,0,0,32'h0);
        checkAll("wrap hold2", 0, 1, 32'hFFFF_FFFC, 32'h2007_0007, 32'h1);
        applyStimulus(0,1,32'h0,0,0,0,32'h0);
        checkAll("wrap zero", 1, 0, 32'h0, 32'h2007_0007, 32'h2);

        // Randomized traffic against the transaction model.
        mReq = 1'b1; mValid = 1'b0; mPc = 32'h0; mInstr = 32'h2007_0007; mCount = 32'h2;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                mReq = 1'b0; mValid = 1'b0; mPc = RST_PC; mInstr = 32'h0; mCount = 32'h0;
                checkAll($sformatf("rnd%0d reset", cyc), mReq, mValid, mPc, mInstr, mCount);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            rAck   = ($urandom_range(0, 1) == 1);
            rReady = ($urandom_range(0, 1) == 1);
            rBr    = ($urandom_range(0, 2) == 0);
            rZ     = ($urandom_range(0, 1) == 1);
            rJ     = ($urandom_range(0, 3) == 0);
            rData  = $urandom;
            rImm   = $urandom_range(0, 64) - 32'd32;
            applyStimulus(rAck, rReady, rData, rBr, rZ, rJ, rImm);
            if (mReq && rAck) begin
                mInstr = rData;
                mReq   = 1'b0;
                mValid = 1'b1;
            end else if (mValid && rReady) begin
                mPc    = modelTarget(mPc, mInstr, rBr, rZ, rJ, rImm);
                mCount = mCount + 32'd1;
                mValid = 1'b0;
                mReq   = 1'b1;
            end else if (!mReq && !mValid) begin
                mReq = 1'b1;
            end
            checkAll($sformatf("rnd%0d", cyc), mReq, mValid, mPc, mInstr, mCount);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
